input_vc_scheduler: RTL and testbench

- Per-input-port read scheduler for the VC_NUM circular_buffer instances of one router input port.
- Each cycle it picks at most one VC with a flit at its head and downstream credit, using round-robin order, and pulses that buffer's read_i.
- Per VC it tracks downstream credits and packet framing (HEAD/BODY/TAIL/HEADTAIL) so malformed packets are flagged.
- It sits between the per-VC buffers and the crossbar input mux; grant_vc_o drives the mux select.

---
 rtl/input_vc_scheduler.sv | 141 ++++++++++++++
 tb/tb_input_vc_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_vc_scheduler.sv
// Round-robin read scheduler for the per-VC buffers of one router input port, with per-VC downstream credit and packet framing checks.
// Zero-latency grant; a VC is skipped while its buffer is empty or it has no credits left.
package noc_params;
  typedef enum logic [1:0] {
    HEAD     = 2'b00,
    BODY     = 2'b01,
    TAIL     = 2'b10,
    HEADTAIL = 2'b11
  } flit_label_t;
endpackage

module input_vc_scheduler
  import noc_params::*;
#(
  parameter int VC_NUM      = 2,
  parameter int BUFFER_SIZE = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [VC_NUM-1:0]                   is_empty_i,
  input  flit_label_t [VC_NUM-1:0]            head_label_i,
  input  logic [VC_NUM-1:0]                   credit_i,
  output logic [VC_NUM-1:0]                   read_o,
  output logic                                valid_o,
  output logic [$clog2(VC_NUM)-1:0]           grant_vc_o,
  output logic                                protocol_err_o
);

  localparam int PW = $clog2(VC_NUM);
  localparam int CW = $clog2(BUFFER_SIZE + 1);
  localparam logic [CW-1:0] CMAX = CW'(BUFFER_SIZE);

  typedef enum logic {IDLE, ACTIVE} pkt_state_t;

  logic [PW-1:0] rr_ptr, rr_ptr_nxt;
  logic [CW-1:0] credit_cnt [VC_NUM];
  logic [CW-1:0] credit_nxt [VC_NUM];
  pkt_state_t    pkt_state  [VC_NUM];
  pkt_state_t    pkt_nxt    [VC_NUM];
  logic          err, err_nxt;
  logic [VC_NUM-1:0] eligible;
  logic          gnt;
  logic [PW-1:0] win;

  always_comb begin
    for (int v = 0; v < VC_NUM; v++) begin
      eligible[v] = ~is_empty_i[v] & (credit_cnt[v] != '0);
    end
  end

  // Scan from the highest offset down so the VC closest to rr_ptr wins last.
  always_comb begin
    gnt = 1'b0;
    win = '0;
    for (int i = VC_NUM - 1; i >= 0; i--) begin
      int idx;
      idx = int'(rr_ptr) + i;
      if (idx >= VC_NUM) idx = idx - VC_NUM;
      if (eligible[idx]) begin
        gnt = 1'b1;
        win = PW'(idx);
      end
    end
  end

  always_comb begin
    read_o     = '0;
    valid_o    = 1'b0;
    grant_vc_o = '0;
    if (gnt && !rst) begin
      read_o[win] = 1'b1;
      valid_o     = 1'b1;
      grant_vc_o  = win;
    end
  end

  assign protocol_err_o = err;

  always_comb begin
    rr_ptr_nxt = rr_ptr;
    err_nxt    = err;
    if (valid_o) begin
      rr_ptr_nxt = (win == PW'(VC_NUM - 1)) ? '0 : win + PW'(1);
    end
    for (int v = 0; v < VC_NUM; v++) begin
      credit_nxt[v] = credit_cnt[v];
      pkt_nxt[v]    = pkt_state[v];
      // A simultaneous read and returned credit cancel out.
      case ({read_o[v], credit_i[v]})
        2'b10: credit_nxt[v] = credit_cnt[v] - CW'(1);
        2'b01: begin
          if (credit_cnt[v] == CMAX) err_nxt = 1'b1;
          else                       credit_nxt[v] = credit_cnt[v] + CW'(1);
        end
        default: ;
      endcase
      if (read_o[v]) begin
        case (pkt_state[v])
          IDLE: begin
            case (head_label_i[v])
              HEAD:     pkt_nxt[v] = ACTIVE;
              HEADTAIL: pkt_nxt[v] = IDLE;
              default:  err_nxt = 1'b1;
            endcase
          end
          ACTIVE: begin
            case (head_label_i[v])
              BODY: pkt_nxt[v] = ACTIVE;
              TAIL: pkt_nxt[v] = IDLE;
              HEAD: err_nxt = 1'b1;
              default: begin
                pkt_nxt[v] = IDLE;
                err_nxt    = 1'b1;
              end
            endcase
          end
          default: pkt_nxt[v] = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      err    <= 1'b0;
      for (int v = 0; v < VC_NUM; v++) begin
        credit_cnt[v] <= CMAX;
        pkt_state[v]  <= IDLE;
      end
    end else begin
      rr_ptr <= rr_ptr_nxt;
      err    <= err_nxt;
      for (int v = 0; v < VC_NUM; v++) begin
        credit_cnt[v] <= credit_nxt[v];
        pkt_state[v]  <= pkt_nxt[v];
      end
    end
  end

endmodule

// File: tb/tb_input_vc_scheduler.sv
// Bench for input_vc_scheduler: queue-based model of the VC buffers and scheduler rules, directed scenarios plus randomized traffic.
module tb_input_vc_scheduler;
  import noc_params::*;

  localparam int VC = 2;
  localparam int BS = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [VC-1:0]     is_empty_i;
  flit_label_t [VC-1:0] head_label_i;
  logic [VC-1:0]     credit_i;
  logic [VC-1:0]     read_o;
  logic              valid_o;
  logic [0:0]        grant_vc_o;
  logic              protocol_err_o;

  always #5 clk = ~clk;

  input_vc_scheduler #(.VC_NUM(VC), .BUFFER_SIZE(BS)) dut (
    .clk            (clk),
    .rst            (rst),
    .is_empty_i     (is_empty_i),
    .head_label_i   (head_label_i),
    .credit_i       (credit_i),
    .read_o         (read_o),
    .valid_o        (valid_o),
    .grant_vc_o     (grant_vc_o),
    .protocol_err_o (protocol_err_o)
  );

  // Model state: buffer contents, credits, packet-open flags, pointer, error.
  flit_label_t q [VC][$];
  int          cred [VC];
  bit          open_pkt [VC];
  int          rr;
  bit          m_err;
  int          rem [VC];

  int          exp_w;
  logic [VC-1:0] cur_cr;
  bit          chk_en;
  int          tests;
  int          fails;

  task automatic chk(input string name, input int a, input int e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, a, e, $time);
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < VC; k++) begin
      int v;
      v = (rr + k) % VC;
      if (q[v].size() != 0 && cred[v] != 0) return v;
    end
    return -1;
  endfunction

  task automatic drive(input logic [VC-1:0] cr);
    for (int v = 0; v < VC; v++) begin
      is_empty_i[v]   = (q[v].size() == 0);
      head_label_i[v] = (q[v].size() != 0) ? q[v][0] : HEAD;
    end
    credit_i = cr;
    cur_cr   = cr;
    #1;
    exp_w  = pick();
    chk_en = 1'b1;
  endtask

  task automatic tick();
    flit_label_t lab;
    @(posedge clk);
    chk_en = 1'b0;
    for (int v = 0; v < VC; v++) begin
      bit rd;
      rd = (exp_w == v);
      if (rd && !cur_cr[v]) cred[v]--;
      else if (!rd && cur_cr[v]) begin
        if (cred[v] == BS) m_err = 1'b1;
        else cred[v]++;
      end
      if (rd) begin
        lab = q[v].pop_front();
        if (!open_pkt[v]) begin
          if (lab == HEAD) open_pkt[v] = 1'b1;
          else if (lab != HEADTAIL) m_err = 1'b1;
        end else begin
          if (lab == TAIL) open_pkt[v] = 1'b0;
          else if (lab == HEAD) m_err = 1'b1;
          else if (lab == HEADTAIL) begin
            open_pkt[v] = 1'b0;
            m_err = 1'b1;
          end
        end
      end
    end
    if (exp_w >= 0) rr = (exp_w + 1) % VC;
    #1;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rst = 1'b1;
    is_empty_i = '0;
    for (int v = 0; v < VC; v++) head_label_i[v] = HEAD;
    credit_i = '0;
    for (int v = 0; v < VC; v++) begin
      q[v].delete();
      cred[v] = BS;
      open_pkt[v] = 1'b0;
      rem[v] = 0;
    end
    rr = 0;
    m_err = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_read", read_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_err", protocol_err_o, 0);
    @(negedge clk);
    is_empty_i = '1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic flit_label_t gen_label(input int v);
    flit_label_t l;
    int len;
    if ($urandom_range(0, 99) == 0) return flit_label_t'($urandom_range(0, 3));
    if (rem[v] == 0) begin
      len = $urandom_range(1, 4);
      if (len == 1) l = HEADTAIL;
      else begin
        l = HEAD;
        rem[v] = len - 1;
      end
    end else begin
      l = (rem[v] == 1) ? TAIL : BODY;
      rem[v]--;
    end
    return l;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("read_o", read_o, (exp_w >= 0) ? (1 << exp_w) : 0);
      chk("valid_o", valid_o, (exp_w >= 0) ? 1 : 0);
      chk("grant_vc_o", grant_vc_o, (exp_w >= 0) ? exp_w : 0);
      chk("protocol_err_o", protocol_err_o, m_err);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nr;
    logic [VC-1:0] cr;
    tests  = 0;
    fails  = 0;
    chk_en = 1'b0;
    exp_w  = -1;

    // Single VC carrying a three-flit packet.
    do_reset();
    q[0].push_back(HEAD); q[0].push_back(BODY); q[0].push_back(TAIL);
    for (int i = 0; i < 3; i++) begin
      drive('0);
      chk("s1_read", read_o, 1);
      chk("s1_gnt", grant_vc_o, 0);
      tick();
    end
    chk("s1_cred0", cred[0], 5);
    chk("s1_state0", open_pkt[0], 0);
    drive('0);
    chk("s1_idle", read_o, 0);
    chk("s1_err", protocol_err_o, 0);
    tick();

    // Round-robin alternation and pointer wrap.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      q[0].push_back(HEADTAIL); q[1].push_back(HEADTAIL);
    end
    for (int i = 0; i < 4; i++) begin
      drive('0);
      chk("s2_gnt", grant_vc_o, i % 2);
      tick();
    end
    chk("s2_rr", rr, 0);
    q[0].push_back(HEADTAIL); q[1].push_back(HEADTAIL);
    drive('0);
    chk("s2_wrap", grant_vc_o, 0);
    tick();

    // Credit exhaustion and a single returned credit.
    do_reset();
    q[0].push_back(HEAD);
    for (int i = 0; i < 7; i++) q[0].push_back(BODY);
    q[0].push_back(TAIL);
    nr = 0;
    for (int i = 0; i < 12; i++) begin
      drive('0);
      nr += int'(read_o[0]);
      tick();
    end
    chk("s3_reads", nr, 8);
    drive('0);
    chk("s3_stall", read_o, 0);
    tick();
    drive(2'b01);
    chk("s3_credit_cycle", read_o, 0);
    tick();
    drive('0);
    chk("s3_after_credit", read_o, 1);
    tick();
    drive('0);
    chk("s3_one_only", read_o, 0);
    tick();
    chk("s3_err", protocol_err_o, 0);

    // Read and credit in the same cycle, then overflow.
    do_reset();
    for (int i = 0; i < 6; i++) q[1].push_back(HEADTAIL);
    for (int i = 0; i < 5; i++) begin
      drive('0);
      tick();
    end
    chk("s4_pre", cred[1], 3);
    drive(2'b10);
    chk("s4_rd", read_o, 2);
    tick();
    chk("s4_cred", cred[1], 3);
    for (int i = 0; i < 5; i++) begin
      drive(2'b10);
      tick();
    end
    chk("s4_noerr", protocol_err_o, 0);
    drive(2'b10);
    tick();
    chk("s4_ovf", protocol_err_o, 1);

    // Framing error is sticky.
    do_reset();
    q[0].push_back(BODY);
    drive('0);
    tick();
    chk("s5_err", protocol_err_o, 1);
    q[0].push_back(HEAD); q[0].push_back(TAIL); q[1].push_back(HEADTAIL);
    for (int i = 0; i < 4; i++) begin
      drive('0);
      tick();
    end
    chk("s5_sticky", protocol_err_o, 1);

    // Asynchronous reset in the middle of a packet.
    do_reset();
    q[0].push_back(HEAD);
    for (int i = 0; i < 5; i++) q[0].push_back(BODY);
    for (int i = 0; i < 4; i++) begin
      drive('0);
      tick();
    end
    chk("s6_cred", cred[0], 4);
    chk("s6_open", open_pkt[0], 1);
    drive('0);
    chk("s6_rd", read_o, 1);
    chk_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("s6_abort", read_o, 0);
    chk("s6_abort_vld", valid_o, 0);
    do_reset();
    q[0].push_back(HEADTAIL); q[1].push_back(HEADTAIL);
    drive('0);
    chk("s6_rr", grant_vc_o, 0);
    tick();
    drive('0);
    tick();
    chk("s6_idle", protocol_err_o, 0);
    drive(2'b01);
    tick();
    chk("s6_cred_refill", protocol_err_o, 0);
    drive(2'b01);
    tick();
    chk("s6_cred_full", protocol_err_o, 1);

    // Randomized traffic against the model.
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      for (int c = 0; c < 300; c++) begin
        for (int v = 0; v < VC; v++) begin
          if (q[v].size() < 6 && $urandom_range(0, 1) == 1) q[v].push_back(gen_label(v));
          cr[v] = (cred[v] < BS && $urandom_range(0, 2) == 0) || ($urandom_range(0, 400) == 0);
        end
        drive(cr);
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
